// File: rtl/muldiv_scheduler.sv
// Issues the slot-1 then slot-2 mul/div ops of a dual-issue EXE bundle to the shared
// multiplier and divider, stalls EXE until both results are registered, and drains flushed divisions.
module muldiv_scheduler #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_valid,
  input  logic        es_go,
  input  logic        flush,
  input  logic        inst1_mul,
  input  logic        inst1_div,
  input  logic        inst1_signed,
  input  logic        inst1_ex,
  input  logic [31:0] inst1_src1,
  input  logic [31:0] inst1_src2,
  input  logic        inst2_mul,
  input  logic        inst2_div,
  input  logic        inst2_signed,
  input  logic        inst2_ex,
  input  logic [31:0] inst2_src1,
  input  logic [31:0] inst2_src2,
  output logic        mul_valid,
  output logic        mul_signed,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [63:0] mul_res,
  output logic        div_in_valid,
  input  logic        div_in_ready,
  output logic        div_signed,
  output logic [31:0] div_src1,
  output logic [31:0] div_src2,
  input  logic        div_out_valid,
  input  logic [63:0] div_res,
  output logic        md_stall,
  output logic [63:0] md1_res,
  output logic [63:0] md2_res,
  output logic        md_busy
);

  localparam int unsigned CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_REQ,
    S_DIV_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               slot2_q, slot2_d;
  logic [63:0]        md1_res_q, md1_res_d;
  logic [63:0]        md2_res_q, md2_res_d;

  logic               need1_c, need2_c, need_any_c;
  logic               cap_c;
  logic [63:0]        cap_val_c;

  // A slot-1 exception also kills slot 2 (younger instruction).
  assign need1_c    = (inst1_mul | inst1_div) & ~inst1_ex;
  assign need2_c    = (inst2_mul | inst2_div) & ~inst2_ex & ~inst1_ex;
  assign need_any_c = need1_c | need2_c;

  // Operands follow the current slot for the whole operation.
  assign mul_signed = slot2_q ? inst2_signed : inst1_signed;
  assign mul_src1   = slot2_q ? inst2_src1   : inst1_src1;
  assign mul_src2   = slot2_q ? inst2_src2   : inst1_src2;
  assign div_signed = slot2_q ? inst2_signed : inst1_signed;
  assign div_src1   = slot2_q ? inst2_src1   : inst1_src1;
  assign div_src2   = slot2_q ? inst2_src2   : inst1_src2;

  assign md_stall = resetn & es_valid & (state_q != S_DONE) &
                    ((state_q != S_IDLE) | need_any_c);
  assign md_busy  = (state_q != S_IDLE);
  assign md1_res  = md1_res_q;
  assign md2_res  = md2_res_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    slot2_d      = slot2_q;
    md1_res_d    = md1_res_q;
    md2_res_d    = md2_res_q;
    cap_c        = 1'b0;
    cap_val_c    = mul_res;
    mul_valid    = 1'b0;
    div_in_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (es_valid && need_any_c) begin
          slot2_d = ~need1_c;
          cnt_d   = '0;
          state_d = (need1_c ? inst1_div : inst2_div) ? S_DIV_REQ : S_MUL;
        end
      end
      S_MUL: begin
        mul_valid = (cnt_q == '0);
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_LAT)) begin
          cap_c     = ~flush;
          cap_val_c = mul_res;
        end
      end
      S_DIV_REQ: begin
        div_in_valid = 1'b1;
        if (div_in_ready) state_d = S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        cap_c     = div_out_valid & ~flush;
        cap_val_c = div_res;
      end
      S_DONE: begin
        if (es_go) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (div_out_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Capture into the current slot, then either start slot 2 or finish.
    if (cap_c) begin
      if (slot2_q) md2_res_d = cap_val_c;
      else         md1_res_d = cap_val_c;
      if (!slot2_q && need2_c) begin
        slot2_d = 1'b1;
        cnt_d   = '0;
        state_d = inst2_div ? S_DIV_REQ : S_MUL;
      end else begin
        state_d = S_DONE;
      end
    end

    // A division the divider has accepted must be drained before reuse.
    if (flush) begin
      case (state_q)
        S_DIV_REQ:  state_d = div_in_ready ? S_DRAIN : S_IDLE;
        S_DIV_WAIT: state_d = div_out_valid ? S_IDLE : S_DRAIN;
        S_DRAIN:    state_d = div_out_valid ? S_IDLE : S_DRAIN;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      slot2_q   <= 1'b0;
      md1_res_q <= '0;
      md2_res_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot2_q   <= slot2_d;
      md1_res_q <= md1_res_d;
      md2_res_q <= md2_res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Randomized bench for muldiv_scheduler: multiplier/divider environment models plus a
// bundle-level reference (issue order, per-slot results, stall length) derived from the op rules.
`timescale 1ns/1ps
module tb_muldiv_scheduler;
  localparam int unsigned MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        es_valid = 1'b0, es_go = 1'b0, flush = 1'b0;
  logic        inst1_mul = 1'b0, inst1_div = 1'b0, inst1_signed = 1'b0, inst1_ex = 1'b0;
  logic [31:0] inst1_src1 = '0, inst1_src2 = '0;
  logic        inst2_mul = 1'b0, inst2_div = 1'b0, inst2_signed = 1'b0, inst2_ex = 1'b0;
  logic [31:0] inst2_src1 = '0, inst2_src2 = '0;
  logic        mul_valid, mul_signed;
  logic [31:0] mul_src1, mul_src2;
  logic [63:0] mul_res;
  logic        div_in_valid, div_in_ready, div_signed;
  logic [31:0] div_src1, div_src2;
  logic        div_out_valid;
  logic [63:0] div_res;
  logic        md_stall, md_busy;
  logic [63:0] md1_res, md2_res;

  always #5 clk = ~clk;

  muldiv_scheduler #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .es_valid(es_valid), .es_go(es_go), .flush(flush),
    .inst1_mul(inst1_mul), .inst1_div(inst1_div), .inst1_signed(inst1_signed), .inst1_ex(inst1_ex),
    .inst1_src1(inst1_src1), .inst1_src2(inst1_src2),
    .inst2_mul(inst2_mul), .inst2_div(inst2_div), .inst2_signed(inst2_signed), .inst2_ex(inst2_ex),
    .inst2_src1(inst2_src1), .inst2_src2(inst2_src2),
    .mul_valid(mul_valid), .mul_signed(mul_signed), .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_res(mul_res),
    .div_in_valid(div_in_valid), .div_in_ready(div_in_ready), .div_signed(div_signed),
    .div_src1(div_src1), .div_src2(div_src2), .div_out_valid(div_out_valid), .div_res(div_res),
    .md_stall(md_stall), .md1_res(md1_res), .md2_res(md2_res), .md_busy(md_busy)
  );

  typedef struct packed {
    logic mul; logic div; logic sgn; logic ex; logic [31:0] a; logic [31:0] b;
  } op_t;
  typedef struct packed {
    logic is_div; logic sgn; logic [31:0] a; logic [31:0] b;
  } iss_t;

  iss_t        exp_iss[$];
  logic [63:0] exp_md1 = '0, exp_md2 = '0;
  logic        p_n1, p_n2;
  logic [63:0] p_r1, p_r2;
  int          p_stall;
  int          n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = a;
      sb = b;
      return {32'(sa / sb), 32'(sa % sb)};
    end
    return {a / b, a % b};
  endfunction

  function automatic op_t mk_op(input logic m, input logic d, input logic s, input logic e,
                                input logic [31:0] a, input logic [31:0] b);
    return {m, d, s, e, a, b};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  k;
    k     = int'($urandom_range(0, 2));
    o.mul = (k == 1);
    o.div = (k == 2);
    o.sgn = 1'($urandom_range(0, 1));
    o.ex  = ($urandom_range(0, 7) == 0);
    o.a   = $urandom;
    o.b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
    if (o.b == 32'd0) o.b = 32'd1;
    if (o.sgn && o.a == 32'h8000_0000 && o.b == 32'hFFFF_FFFF) o.a = 32'd5;
    return o;
  endfunction

  // Multiplier environment: product appears MUL_LAT cycles after sampling, garbage otherwise.
  logic [63:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_valid ? ref_mul(mul_signed, mul_src1, mul_src2) : {$urandom, $urandom};
    for (int i = 1; i < int'(MUL_LAT); i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_res = mpipe[MUL_LAT-1];

  // Divider environment: single in-flight op, result pulse dv_lat cycles after accept.
  logic        dv_busy, rdy_rand;
  int          dv_cnt;
  int          dv_lat = 4;
  int          rdy_mode = 0;
  logic [63:0] dv_pend;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dv_busy <= 1'b0; dv_cnt <= 0; dv_pend <= '0;
      div_out_valid <= 1'b0; div_res <= '0; rdy_rand <= 1'b0;
    end else begin
      rdy_rand      <= ($urandom_range(0, 3) != 0);
      div_out_valid <= 1'b0;
      div_res       <= {$urandom, $urandom};
      if (div_in_valid && div_in_ready) begin
        dv_busy <= 1'b1;
        dv_cnt  <= dv_lat;
        dv_pend <= ref_div(div_signed, div_src1, div_src2);
      end else if (dv_busy) begin
        if (dv_cnt <= 1) begin
          dv_busy <= 1'b0; div_out_valid <= 1'b1; div_res <= dv_pend;
        end else begin
          dv_cnt <= dv_cnt - 1;
        end
      end
    end
  end
  assign div_in_ready = !dv_busy && (rdy_mode == 1 || (rdy_mode == 0 && rdy_rand));

  task automatic issue_seen(input logic is_div, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    iss_t e;
    check_eq(is_div ? "div_issue_expected" : "mul_issue_expected", 64'(exp_iss.size() != 0), 64'd1);
    if (exp_iss.size() == 0) return;
    e = exp_iss.pop_front();
    check_eq("issue_kind", {62'd0, is_div, sgn}, {62'd0, e.is_div, e.sgn});
    check_eq("issue_operands", {a, b}, {e.a, e.b});
  endtask

  // Issue monitor, sampling mid-cycle after stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (resetn) begin
      if (mul_valid) issue_seen(1'b0, mul_signed, mul_src1, mul_src2);
      if (div_in_valid && div_in_ready) issue_seen(1'b1, div_signed, div_src1, div_src2);
      if (dv_busy) check_eq("div_req_while_busy", 64'(div_in_valid), 64'd0);
    end
  end

  task automatic start_bundle(input op_t o1, input op_t o2);
    logic n1, n2;
    n1 = (o1.mul | o1.div) & ~o1.ex;
    n2 = (o2.mul | o2.div) & ~o2.ex & ~o1.ex;
    p_n1 = n1; p_n2 = n2;
    p_r1 = o1.div ? ref_div(o1.sgn, o1.a, o1.b) : ref_mul(o1.sgn, o1.a, o1.b);
    p_r2 = o2.div ? ref_div(o2.sgn, o2.a, o2.b) : ref_mul(o2.sgn, o2.a, o2.b);
    if (n1) exp_iss.push_back({o1.div, o1.sgn, o1.a, o1.b});
    if (n2) exp_iss.push_back({o2.div, o2.sgn, o2.a, o2.b});
    if ((n1 && o1.div) || (n2 && o2.div)) p_stall = -1;
    else if (!n1 && !n2) p_stall = 0;
    else p_stall = (int'(n1) + int'(n2)) * (int'(MUL_LAT) + 1) + 1;
    es_valid = 1'b1;
    inst1_mul = o1.mul; inst1_div = o1.div; inst1_signed = o1.sgn; inst1_ex = o1.ex;
    inst1_src1 = o1.a; inst1_src2 = o1.b;
    inst2_mul = o2.mul; inst2_div = o2.div; inst2_signed = o2.sgn; inst2_ex = o2.ex;
    inst2_src1 = o2.a; inst2_src2 = o2.b;
  endtask

  task automatic finish_bundle(input string tag);
    int   stall;
    logic timeout;
    stall = 0;
    timeout = 1'b0;
    #1;
    while (md_stall) begin
      stall++;
      if (stall > 300) begin timeout = 1'b1; break; end
      @(negedge clk); #1;
    end
    check_eq({tag, "_timeout"}, 64'(timeout), 64'd0);
    if (p_n1) exp_md1 = p_r1;
    if (p_n2) exp_md2 = p_r2;
    if (p_stall >= 0) check_eq({tag, "_stall_cycles"}, 64'(stall), 64'(p_stall));
    check_eq({tag, "_md1_res"}, md1_res, exp_md1);
    check_eq({tag, "_md2_res"}, md2_res, exp_md2);
    es_go = 1'b1;
    @(posedge clk); #1;
    es_go = 1'b0;
    es_valid = 1'b0;
    check_eq({tag, "_idle_after_go"}, 64'(md_busy), 64'd0);
    check_eq({tag, "_issues_left"}, 64'(exp_iss.size()), 64'd0);
    exp_iss.delete();
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_mul_valid"}, 64'(mul_valid), 64'd0);
    check_eq({tag, "_div_in_valid"}, 64'(div_in_valid), 64'd0);
    check_eq({tag, "_md_stall"}, 64'(md_stall), 64'd0);
    check_eq({tag, "_md_busy"}, 64'(md_busy), 64'd0);
    check_eq({tag, "_md1_res"}, md1_res, 64'd0);
    check_eq({tag, "_md2_res"}, md2_res, 64'd0);
  endtask

  initial begin
    #200000;
    check_eq("watchdog_expired", 64'd1, 64'(n_checks < 0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  op_t none_op;
  int  guard;

  initial begin
    none_op = mk_op(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    #1 check_quiet("reset");
    resetn = 1'b1;

    // Signed mult -1 * 2 in slot 1.
    rdy_mode = 0;
    @(negedge clk);
    start_bundle(mk_op(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2), none_op);
    finish_bundle("mult_neg");
    check_eq("mult_neg_value", md1_res, 64'hFFFF_FFFF_FFFF_FFFE);

    // divu 7/2 then mult 3*4 in one bundle.
    dv_lat = 10; rdy_mode = 1;
    @(negedge clk);
    start_bundle(mk_op(1'b0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd2), mk_op(1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 32'd4));
    finish_bundle("div_mul");
    check_eq("div_mul_q_r", md1_res, {32'd3, 32'd1});
    check_eq("div_mul_prod", md2_res, 64'h0000_0000_0000_000C);

    // Slot-1 exception kills both slots.
    @(negedge clk);
    start_bundle(mk_op(1'b0, 1'b1, 1'b0, 1'b1, 32'd9, 32'd3), mk_op(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd6));
    finish_bundle("ex_kill");

    // Flush in DIV_WAIT drains; a new slot-2 div waits for the stale result.
    dv_lat = 6; rdy_mode = 1;
    @(negedge clk);
    start_bundle(mk_op(1'b0, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7), none_op);
    @(negedge clk);
    @(negedge clk);
    #1 check_eq("drain_pre_busy", 64'(md_busy), 64'd1);
    flush = 1'b1; es_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    exp_iss.delete();
    start_bundle(none_op, mk_op(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FF00, 32'd16));
    #1 check_eq("drain_state_busy", 64'(md_busy), 64'd1);
    guard = 0;
    while (!div_out_valid && guard < 50) begin
      check_eq("drain_stall", 64'(md_stall), 64'd1);
      check_eq("drain_no_req", 64'(div_in_valid), 64'd0);
      guard++;
      @(negedge clk); #1;
    end
    check_eq("drain_stale_seen", 64'(div_out_valid), 64'd1);
    check_eq("drain_stale_stall", 64'(md_stall), 64'd1);
    @(negedge clk); #1;
    check_eq("drain_idle_no_req", 64'(div_in_valid), 64'd0);
    check_eq("drain_idle_stall", 64'(md_stall), 64'd1);
    @(negedge clk); #1;
    check_eq("drain_new_req", 64'(div_in_valid), 64'd1);
    finish_bundle("after_drain");

    // Flush with div_in_ready in DIV_REQ must drain.
    dv_lat = 4; rdy_mode = 2;
    @(negedge clk);
    start_bundle(mk_op(1'b0, 1'b1, 1'b0, 1'b0, 32'd50, 32'd5), none_op);
    @(negedge clk);
    #1 check_eq("req_asserted", 64'(div_in_valid), 64'd1);
    rdy_mode = 1; flush = 1'b1; es_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    exp_iss.delete();
    #1 check_eq("flush_ready_drain", 64'(md_busy), 64'd1);
    guard = 0;
    while (!div_out_valid && guard < 30) begin
      guard++;
      @(negedge clk); #1;
    end
    check_eq("flush_ready_result", 64'(div_out_valid), 64'd1);
    @(negedge clk); #1;
    check_eq("flush_ready_exit", 64'(md_busy), 64'd0);
    check_eq("flush_ready_md1_kept", md1_res, exp_md1);

    // Flush in DIV_REQ without ready goes straight to IDLE.
    rdy_mode = 2;
    @(negedge clk);
    start_bundle(mk_op(1'b0, 1'b1, 1'b1, 1'b0, 32'd77, 32'd3), none_op);
    @(negedge clk);
    #1 flush = 1'b1; es_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    exp_iss.delete();
    #1 check_eq("flush_noready_idle", 64'(md_busy), 64'd0);
    rdy_mode = 0;

    // Randomized bundles.
    for (int k = 0; k < 40; k++) begin
      dv_lat = int'($urandom_range(1, 8));
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
      @(negedge clk);
      start_bundle(rand_op(), rand_op());
      finish_bundle("rnd");
    end

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start_bundle(mk_op(1'b1, 1'b0, 1'b0, 1'b0, 32'd11, 32'd13), none_op);
    @(negedge clk);
    @(negedge clk);
    #1 check_eq("pre_reset_busy", 64'(md_busy), 64'd1);
    resetn = 1'b0;
    #1 check_quiet("mid_mul_reset");
    es_valid = 1'b0;
    exp_iss.delete();
    exp_md1 = '0; exp_md2 = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1 check_quiet("after_reset");

    @(negedge clk);
    start_bundle(mk_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'd3), mk_op(1'b1, 1'b0, 1'b0, 1'b0, 32'd9, 32'hFFFF_FFFF));
    finish_bundle("post_reset_two_mul");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
